// File: rtl/screen_cache_fill_pkg.sv
// screen_fill_pkg: shared types and constants for the screen cache filler.
// Holds the fill FSM state enum and the screen geometry constants.
package screen_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WR   = 2'd2,
    ST_GAP  = 2'd3
  } fill_state_t;

  localparam int WORDS_PER_SCREEN = 8192;
  localparam int SCREEN_WORD_AW   = 14;

  // Word pointer landmarks within the 16K-word screen space.
  localparam logic [SCREEN_WORD_AW-1:0] LAST_S0_WORD  = SCREEN_WORD_AW'(WORDS_PER_SCREEN - 1);
  localparam logic [SCREEN_WORD_AW-1:0] FIRST_S1_WORD = SCREEN_WORD_AW'(WORDS_PER_SCREEN);
  localparam logic [SCREEN_WORD_AW-1:0] LAST_S1_WORD  = '1;

endpackage

// File: rtl/screen_cache_fill_if.sv
// screen_cache_fill_if: Wishbone initiator bus used by the screen cache filler.
//   m_adr   : byte address within the 32 KB screen space (bit0 always 0)
//   m_cyc   : cycle, m_stb : strobe, m_we : write enable, m_sel : byte selects
//   m_dat_i : read data from responder, m_ack : responder acknowledge
// Modports: master (the filler), slave (the memory responder).
interface screen_cache_fill_if;
  import screen_fill_pkg::*;

  logic [SCREEN_WORD_AW:0] m_adr;
  logic                    m_cyc;
  logic                    m_stb;
  logic                    m_we;
  logic [1:0]              m_sel;
  logic [15:0]             m_dat_i;
  logic                    m_ack;

  modport master (
    output m_adr, m_cyc, m_stb, m_we, m_sel,
    input  m_dat_i, m_ack
  );

  modport slave (
    input  m_adr, m_cyc, m_stb, m_we, m_sel,
    output m_dat_i, m_ack
  );

endinterface

// File: rtl/screen_cache_fill.sv
// screen_cache_fill: fills the video cache from screen memory over Wishbone
// while passing CPU writes (snoops) straight through to the cache.
// Ports:
//   wb_clk, sys_init        : clock, asynchronous active-high reset
//   fill_start, fill_screen : fill request pulse, screen select (bit0 = screen 0,
//                             bit1 = screen 1)
//   fill_busy, fill_done    : fill in progress, one-cycle completion pulse
//   wb                      : Wishbone initiator (screen_cache_fill_if.master)
//   snoop_*                 : CPU write into screen space (byte addr, data, byte enables)
//   cache_*                 : registered write port into the video cache
// Parameter GAP: idle cycles between consecutive fill reads.
// Optional macro SCREEN_CACHE_FILL_AUTOSTART_EN: start a both-screen fill on the
// first cycle after reset release.
module screen_cache_fill
  import screen_fill_pkg::*;
#(
  parameter int GAP = 2
) (
  input  logic                      wb_clk,
  input  logic                      sys_init,
  input  logic                      fill_start,
  input  logic [1:0]                fill_screen,
  output logic                      fill_busy,
  output logic                      fill_done,
  screen_cache_fill_if.master       wb,
  input  logic                      snoop_we,
  input  logic [SCREEN_WORD_AW:0]   snoop_addr,
  input  logic [15:0]               snoop_data,
  input  logic [1:0]                snoop_wtbt,
  output logic [SCREEN_WORD_AW:0]   cache_addr,
  output logic [15:0]               cache_data,
  output logic [1:0]                cache_wtbt,
  output logic                      cache_we
);

  localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;

  fill_state_t               r_state;
  logic [SCREEN_WORD_AW-1:0] r_ptr;
  logic [1:0]                r_scr;
  logic [1:0]                r_mask;
  logic [15:0]               r_data;
  logic [GW-1:0]             r_gap;
  logic                      r_done;
  logic                      r_cache_we;
  logic [SCREEN_WORD_AW:0]   r_cache_addr;
  logic [15:0]               r_cache_data;
  logic [1:0]                r_cache_wtbt;

  logic                      w_start;
  logic [1:0]                w_screen;
  logic                      w_last;
  logic                      w_hit;

`ifdef SCREEN_CACHE_FILL_AUTOSTART_EN
  logic r_boot;

  always_ff @(posedge wb_clk or posedge sys_init) begin
    if (sys_init) r_boot <= 1'b1;
    else          r_boot <= 1'b0;
  end

  assign w_start  = fill_start | r_boot;
  assign w_screen = r_boot ? 2'b11 : fill_screen;
`else
  assign w_start  = fill_start;
  assign w_screen = fill_screen;
`endif

  // End of screen 0 finishes only when screen 1 is not latched; otherwise
  // pointer+1 naturally lands on the first screen-1 word.
  assign w_last = (r_ptr == LAST_S1_WORD) || ((r_ptr == LAST_S0_WORD) && !r_scr[1]);
  assign w_hit  = snoop_we && (snoop_addr[SCREEN_WORD_AW:1] == r_ptr) &&
                  ((r_state == ST_REQ) || (r_state == ST_WR));

  always_ff @(posedge wb_clk or posedge sys_init) begin
    if (sys_init) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_scr        <= '0;
      r_mask       <= '0;
      r_data       <= '0;
      r_gap        <= '0;
      r_done       <= 1'b0;
      r_cache_we   <= 1'b0;
      r_cache_addr <= '0;
      r_cache_data <= '0;
      r_cache_wtbt <= '0;
    end else begin
      r_done     <= 1'b0;
      r_cache_we <= 1'b0;

      // Snoop always owns the cache port on the following cycle.
      if (snoop_we) begin
        r_cache_we   <= 1'b1;
        r_cache_addr <= snoop_addr;
        r_cache_data <= snoop_data;
        r_cache_wtbt <= snoop_wtbt;
      end

      // Bytes the CPU wrote to the word in flight must not be overwritten by stale fill data.
      if (w_hit) r_mask <= r_mask & ~snoop_wtbt;

      case (r_state)
        ST_IDLE: begin
          if (w_start && (w_screen != 2'b00)) begin
            r_scr   <= w_screen;
            r_ptr   <= w_screen[0] ? '0 : FIRST_S1_WORD;
            r_mask  <= 2'b11;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (wb.m_ack) begin
            r_data  <= wb.m_dat_i;
            r_state <= ST_WR;
          end
        end
        ST_WR: begin
          if (!snoop_we) begin
            if (r_mask != 2'b00) begin
              r_cache_we   <= 1'b1;
              r_cache_addr <= {r_ptr, 1'b0};
              r_cache_data <= r_data;
              r_cache_wtbt <= r_mask;
            end
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_ptr <= r_ptr + 1'b1;
              // The WR cycle itself is the first idle bus cycle, so GAP
              // holds for GAP-1 cycles and GAP <= 1 goes straight to REQ.
              if (GAP > 1) begin
                r_gap   <= GW'(GAP - 2);
                r_state <= ST_GAP;
              end else begin
                r_mask  <= 2'b11;
                r_state <= ST_REQ;
              end
            end
          end
        end
        ST_GAP: begin
          if (r_gap == '0) begin
            r_mask  <= 2'b11;
            r_state <= ST_REQ;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wb.m_cyc   = (r_state == ST_REQ);
  assign wb.m_stb   = (r_state == ST_REQ);
  assign wb.m_adr   = {r_ptr, 1'b0};
  assign wb.m_we    = 1'b0;
  assign wb.m_sel   = 2'b11;

  assign fill_busy  = (r_state != ST_IDLE);
  assign fill_done  = r_done;
  assign cache_we   = r_cache_we;
  assign cache_addr = r_cache_addr;
  assign cache_data = r_cache_data;
  assign cache_wtbt = r_cache_wtbt;

endmodule

// File: tb/tb_screen_cache_fill.sv
// tb_screen_cache_fill: self-checking bench for screen_cache_fill.
// The bench keeps a queue of the fill writes the specification requires
// (word order from the screen select, data from the responder rule, byte
// mask from the injected snoops) and checks every cache write against it,
// plus snoop pass-through on the following cycle.
module tb_screen_cache_fill;
  import screen_fill_pkg::*;

  localparam int GAP_P = 2;

  logic        wb_clk = 1'b0;
  logic        sys_init;
  logic        fill_start;
  logic [1:0]  fill_screen;
  logic        fill_busy;
  logic        fill_done;
  logic        snoop_we;
  logic [14:0] snoop_addr;
  logic [15:0] snoop_data;
  logic [1:0]  snoop_wtbt;
  logic [14:0] cache_addr;
  logic [15:0] cache_data;
  logic [1:0]  cache_wtbt;
  logic        cache_we;

  screen_cache_fill_if wb ();

  screen_cache_fill #(.GAP(GAP_P)) dut (
    .wb_clk      (wb_clk),
    .sys_init    (sys_init),
    .fill_start  (fill_start),
    .fill_screen (fill_screen),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .wb          (wb.master),
    .snoop_we    (snoop_we),
    .snoop_addr  (snoop_addr),
    .snoop_data  (snoop_data),
    .snoop_wtbt  (snoop_wtbt),
    .cache_addr  (cache_addr),
    .cache_data  (cache_data),
    .cache_wtbt  (cache_wtbt),
    .cache_we    (cache_we)
  );

  always #5 wb_clk = ~wb_clk;

  // Responder data rule: word index, except word 8 returns 16'hAAAA.
  function automatic logic [15:0] word_data(input logic [13:0] w);
    return (w == 14'd8) ? 16'hAAAA : {2'b00, w};
  endfunction

  // Zero-wait responder with an optional stall on one address.
  logic        stall_en;
  logic [14:0] stall_adr;
  always_comb begin
    wb.m_ack   = wb.m_stb && !(stall_en && (wb.m_adr == stall_adr));
    wb.m_dat_i = word_data(wb.m_adr[14:1]);
  end

  typedef struct {
    logic [13:0] w;
    logic [1:0]  b;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [15:0] img [0:16383];
  int          checks = 0;
  int          passes = 0;
  int          done_cnt = 0;
  int          n;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Previous-cycle snoop, for the one-cycle pass-through rule.
  logic        p_we;
  logic [14:0] p_addr;
  logic [15:0] p_data;
  logic [1:0]  p_wtbt;
  always @(posedge wb_clk or posedge sys_init) begin
    if (sys_init) p_we <= 1'b0;
    else begin
      p_we   <= snoop_we;
      p_addr <= snoop_addr;
      p_data <= snoop_data;
      p_wtbt <= snoop_wtbt;
    end
  end

  always @(negedge wb_clk) begin
    if (!sys_init) begin
      if (p_we) begin
        chk(cache_we && cache_addr == p_addr && cache_data == p_data && cache_wtbt == p_wtbt,
            "snoop_pass", {cache_we, cache_wtbt, cache_addr, cache_data},
            {1'b1, p_wtbt, p_addr, p_data});
      end else if (cache_we) begin
        if (q.size() == 0) begin
          chk(1'b0, "fill_extra", {cache_wtbt, cache_addr, cache_data}, 64'h0);
        end else begin
          e = q.pop_front();
          chk(cache_addr == {e.w, 1'b0} && cache_data == word_data(e.w) && cache_wtbt == e.b,
              "fill_write", {cache_wtbt, cache_addr, cache_data},
              {e.b, e.w, 1'b0, word_data(e.w)});
        end
      end
      if (cache_we) begin
        if (cache_wtbt[0]) img[cache_addr[14:1]][7:0]  = cache_data[7:0];
        if (cache_wtbt[1]) img[cache_addr[14:1]][15:8] = cache_data[15:8];
      end
      if (fill_done) begin
        done_cnt++;
        chk(q.size() == 0, "done_early", 64'(q.size()), 64'h0);
      end
      if (wb.m_cyc) begin
        chk(wb.m_stb && !wb.m_we && wb.m_sel == 2'b11 && fill_busy, "bus_ctl",
            {wb.m_stb, wb.m_we, wb.m_sel, fill_busy}, {1'b1, 1'b0, 2'b11, 1'b1});
      end
    end
  end

  task automatic tick;
    @(posedge wb_clk);
    #1;
  endtask

  task automatic do_reset;
    sys_init = 1'b1;
    tick();
    tick();
    q.delete();
    sys_init = 1'b0;
    tick();
  endtask

  task automatic start_fill(input logic [1:0] s, input bit snoop8);
    exp_t x;
    for (int unsigned w = 0; w < 16384; w++) begin
      if ((w < 8192 && s[0]) || (w >= 8192 && s[1])) begin
        x.w = 14'(w);
        x.b = (snoop8 && w == 8) ? 2'b10 : 2'b11;
        q.push_back(x);
      end
    end
    fill_screen = s;
    fill_start  = 1'b1;
    tick();
    fill_start  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16384; i++) img[i] = '0;
    sys_init    = 1'b1;
    fill_start  = 1'b0;
    fill_screen = 2'b00;
    snoop_we    = 1'b0;
    snoop_addr  = '0;
    snoop_data  = '0;
    snoop_wtbt  = '0;
    stall_en    = 1'b0;
    stall_adr   = '0;
    tick();
    tick();

    chk(!fill_busy && !fill_done, "rst_status", {fill_busy, fill_done}, 64'h0);
    chk(!wb.m_cyc && !wb.m_stb && wb.m_adr == 15'h0, "rst_bus", {wb.m_cyc, wb.m_stb, wb.m_adr}, 64'h0);
    chk(!cache_we && cache_addr == 15'h0 && cache_data == 16'h0 && cache_wtbt == 2'b00, "rst_cache",
        {cache_we, cache_wtbt, cache_addr, cache_data}, 64'h0);

`ifdef SCREEN_CACHE_FILL_AUTOSTART_EN
    sys_init = 1'b0;
    n = 0;
    while (!fill_busy && n < 2) begin
      tick();
      n++;
    end
    chk(fill_busy, "autostart_busy", {63'h0, fill_busy}, 64'h1);
    sys_init = 1'b1;
    tick();
    q.delete();
`else
    sys_init = 1'b0;
    tick();
    repeat (3) tick();
    chk(!fill_busy, "no_autostart", {63'h0, fill_busy}, 64'h0);

    // fill_screen == 0 is ignored
    fill_screen = 2'b00;
    fill_start  = 1'b1;
    tick();
    fill_start  = 1'b0;
    tick();
    chk(!fill_busy && !wb.m_cyc, "start_zero_ignored", {fill_busy, wb.m_cyc}, 64'h0);

    // Screen 1 only: first address and read spacing
    start_fill(2'b10, 1'b0);
    chk(wb.m_stb && wb.m_adr == 15'h4000, "first_adr_s1", {wb.m_stb, wb.m_adr}, {1'b1, 15'h4000});
    for (int i = 0; i < 3; i++) begin
      tick();
      n = 0;
      while (!wb.m_stb && n < 20) begin
        n++;
        tick();
      end
      chk(n == GAP_P, "gap_idle", 64'(n), 64'(GAP_P));
      chk(wb.m_adr == 15'(16'h4000 + 2 * (i + 1)), "next_adr", 64'(wb.m_adr), 64'(16'h4000 + 2 * (i + 1)));
    end

    // fill_start while busy is ignored: the fill continues at word 8196
    fill_screen = 2'b01;
    fill_start  = 1'b1;
    tick();
    fill_start  = 1'b0;
    n = 0;
    while (!wb.m_stb && n < 20) begin
      n++;
      tick();
    end
    chk(wb.m_stb && wb.m_adr == 15'h4008, "busy_start_ignored", {wb.m_stb, wb.m_adr}, {1'b1, 15'h4008});
    do_reset();
    chk(done_cnt == 0, "abort_no_done", 64'(done_cnt), 64'h0);

    // Reset while the fill reads word 100
    start_fill(2'b01, 1'b0);
    n = 0;
    while (!(wb.m_stb && wb.m_adr == 15'd200) && n < 1000) begin
      n++;
      tick();
    end
    chk(wb.m_stb && wb.m_adr == 15'd200, "reach_w100", {wb.m_stb, wb.m_adr}, {1'b1, 15'd200});
    sys_init = 1'b1;
    #1;
    chk(!wb.m_cyc && !fill_busy, "rst_mid_fill", {wb.m_cyc, fill_busy}, 64'h0);
    tick();
    tick();
    q.delete();
    chk(done_cnt == 0, "rst_no_done", 64'(done_cnt), 64'h0);
    chk(img[99] == 16'd99, "pre_rst_write", 64'(img[99]), 64'd99);
    chk(img[100] == 16'h0, "rst_drop_w100", 64'(img[100]), 64'h0);
    sys_init = 1'b0;
    tick();

    // Full screen-0 fill with a masking snoop at word 8 and a snoop burst at word 20
    stall_en  = 1'b1;
    stall_adr = 15'h0010;
    start_fill(2'b01, 1'b1);
    chk(wb.m_stb && wb.m_adr == 15'h0, "restart_w0", {wb.m_stb, wb.m_adr}, {1'b1, 15'h0});
    n = 0;
    while (!(wb.m_stb && wb.m_adr == 15'h0010) && n < 200) begin
      n++;
      tick();
    end
    chk(wb.m_stb && wb.m_adr == 15'h0010, "reach_w8", {wb.m_stb, wb.m_adr}, {1'b1, 15'h0010});
    snoop_we   = 1'b1;
    snoop_addr = 15'h0010;
    snoop_data = 16'h1234;
    snoop_wtbt = 2'b01;
    tick();
    snoop_we = 1'b0;
    stall_en = 1'b0;
    n = 0;
    while (!(wb.m_stb && wb.m_adr == 15'h0012) && n < 20) begin
      n++;
      tick();
    end
    chk(img[8] == 16'hAA34, "merge_w8", 64'(img[8]), 64'hAA34);

    n = 0;
    while (!(wb.m_stb && wb.m_adr == 15'd40) && n < 200) begin
      n++;
      tick();
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      snoop_we   = 1'b1;
      snoop_addr = 15'(16'h6000 + 2 * k);
      snoop_data = 16'(16'h5000 + k);
      snoop_wtbt = 2'b11;
      tick();
    end
    snoop_we = 1'b0;
    tick();
    chk(cache_we && cache_addr == 15'd40 && cache_data == 16'd20 && cache_wtbt == 2'b11, "stall_write",
        {cache_we, cache_wtbt, cache_addr, cache_data}, {1'b1, 2'b11, 15'd40, 16'd20});

    n = 0;
    while (!fill_done && n < 40000) begin
      n++;
      tick();
    end
    chk(fill_done, "fill_done_seen", {63'h0, fill_done}, 64'h1);
    repeat (5) tick();
    chk(done_cnt == 1, "done_once", 64'(done_cnt), 64'h1);
    chk(!fill_busy, "idle_after", {63'h0, fill_busy}, 64'h0);
    chk(q.size() == 0, "all_written", 64'(q.size()), 64'h0);
    chk(img[8191] == 16'd8191, "last_w", 64'(img[8191]), 64'd8191);
    chk(img[5000] == 16'd5000, "mid_w", 64'(img[5000]), 64'd5000);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
